// File: rtl/niosii_microprocessor_cpu_debug_monitor_pkg.sv
// rtl/niosii_microprocessor_cpu_debug_monitor_pkg.sv - shared types and constants for the debug monitor
// Contents: FSM state enumeration, jdo field positions, default ID word.
package niosii_microprocessor_cpu_debug_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_CAP  = 2'd2
    } mon_state_t;

    // jdo field positions
    localparam int JDO_ADDR_MSB = 33;
    localparam int JDO_ADDR_LSB = 26;
    localparam int JDO_RD_BIT   = 34;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_DATA_LSB = 3;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h4E49_4F53;

endpackage

// File: rtl/niosii_microprocessor_cpu_debug_monitor_ram.sv
// rtl/niosii_microprocessor_cpu_debug_monitor_ram.sv - 256x32 single-port debug RAM, 1-cycle synchronous read
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata to mem[addr]
//   re    - read enable, rdata <= mem[addr] on the next edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
module niosii_microprocessor_cpu_debug_monitor_ram (
    input  logic        clk,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    // Contents are deliberately not reset so debug data survives a reset.
    logic [31:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/niosii_microprocessor_cpu_debug_monitor.sv
// rtl/niosii_microprocessor_cpu_debug_monitor.sv - JTAG-driven debug memory monitor (RAM window + read-only ID word)
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   jdo                     - JTAG data word (address/read bit/write data fields)
//   take_action_ocimem_a    - set-address strobe (optional read)
//   take_action_ocimem_b    - write strobe
//   take_no_action_ocimem_a - read-next strobe
//   MonDReg                 - last read data
//   MonAReg                 - current word address
//   monitor_ready           - last access complete
//   monitor_error           - last access faulted
module niosii_microprocessor_cpu_debug_monitor
    import niosii_microprocessor_cpu_debug_monitor_pkg::*;
#(
    parameter int          RAM_WORDS = 240,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID_VALUE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic [7:0]  MonAReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    mon_state_t  state, state_nxt;
    logic        active;
    logic        stray, stray_nxt;
    logic [7:0]  addr_nxt;
    logic [31:0] dreg_nxt;
    logic        ready_nxt, error_nxt;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;
    logic        in_ram;
    logic        strobe_any;
    logic        unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign in_ram     = (32'(MonAReg) < RAM_WORDS);
    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Clears asynchronously with reset, sets on the first edge after release,
    // so strobes in that first cycle are not acted on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            MonAReg       <= 8'h00;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            stray         <= 1'b0;
        end else begin
            state         <= state_nxt;
            MonAReg       <= addr_nxt;
            MonDReg       <= dreg_nxt;
            monitor_ready <= ready_nxt;
            monitor_error <= error_nxt;
            stray         <= stray_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = MonAReg;
        dreg_nxt  = MonDReg;
        ready_nxt = monitor_ready;
        error_nxt = monitor_error;
        stray_nxt = stray;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    if (take_action_ocimem_b) begin
                        ram_we    = in_ram;
                        error_nxt = ~in_ram;
                        ready_nxt = 1'b1;
                        addr_nxt  = MonAReg + 8'd1;
                    end else if (take_action_ocimem_a) begin
                        addr_nxt  = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                        error_nxt = 1'b0;
                        stray_nxt = 1'b0;
                        // A plain address load completes immediately; a read waits for RD_CAP.
                        ready_nxt = ~jdo[JDO_RD_BIT];
                        if (jdo[JDO_RD_BIT]) begin
                            state_nxt = ST_RD_WAIT;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        ready_nxt = 1'b0;
                        error_nxt = 1'b0;
                        stray_nxt = 1'b0;
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                ram_re    = 1'b1;
                stray_nxt = stray | strobe_any;
                state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                dreg_nxt  = in_ram ? ram_rdata : ID_VALUE;
                ready_nxt = 1'b1;
                error_nxt = stray | strobe_any;
                stray_nxt = 1'b0;
                addr_nxt  = MonAReg + 8'd1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    niosii_microprocessor_cpu_debug_monitor_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (MonAReg),
        .wdata (jdo[JDO_DATA_MSB:JDO_DATA_LSB]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_niosii_microprocessor_cpu_debug_monitor.sv
// tb/tb_niosii_microprocessor_cpu_debug_monitor.sv - directed self-checking bench for the debug monitor
module tb_niosii_microprocessor_cpu_debug_monitor;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_n;
    logic [31:0] mon_d;
    logic [7:0]  mon_a;
    logic        ready, error;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ID_WORD = 32'h4E49_4F53;

    niosii_microprocessor_cpu_debug_monitor dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .MonDReg                 (mon_d),
        .MonAReg                 (mon_a),
        .monitor_ready           (ready),
        .monitor_error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; holds the strobe for one rising edge.
    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] d);
        jdo = d; take_a = a; take_b = b; take_n = n;
        @(negedge clk);
        take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    endtask

    function automatic logic [37:0] addr_word(input logic [7:0] a, input logic rd);
        return {3'b000, rd, a, 26'h0};
    endfunction

    function automatic logic [37:0] data_word(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    // Read completes 3 cycles after the strobe cycle.
    task automatic expect_read(input string tag, input logic [31:0] d, input logic [7:0] a, input logic e);
        check({tag, "_rdy_c1"}, 32'(ready), 32'd0);
        @(negedge clk);
        check({tag, "_rdy_c2"}, 32'(ready), 32'd0);
        @(negedge clk);
        check({tag, "_rdy_c3"}, 32'(ready), 32'd1);
        check({tag, "_dreg"},   mon_d, d);
        check({tag, "_areg"},   32'(mon_a), 32'(a));
        check({tag, "_err"},    32'(error), 32'(e));
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0; take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_areg",  32'(mon_a), 32'd0);
        check("rst_dreg",  mon_d,      32'd0);

        // Strobe present in the first cycle after release must be ignored.
        reset_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h33, 1'b0));
        check("first_cycle_ignored", 32'(mon_a), 32'd0);
        @(negedge clk);

        // Set address without read
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h10, 1'b0));
        check("seta_areg",  32'(mon_a), 32'h10);
        check("seta_ready", 32'(ready), 32'd1);
        check("seta_dreg",  mon_d,      32'd0);
        check("seta_err",   32'(error), 32'd0);

        // Two writes
        pulse(1'b0, 1'b1, 1'b0, data_word(32'hDEADBEEF));
        check("wr1_areg",  32'(mon_a), 32'h11);
        check("wr1_ready", 32'(ready), 32'd1);
        check("wr1_err",   32'(error), 32'd0);
        check("wr1_dreg",  mon_d,      32'd0);
        pulse(1'b0, 1'b1, 1'b0, data_word(32'h12345678));
        check("wr2_areg",  32'(mon_a), 32'h12);

        // Read back
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h10, 1'b1));
        expect_read("rd1", 32'hDEADBEEF, 8'h11, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, '0);
        expect_read("rd2", 32'h12345678, 8'h12, 1'b0);

        // Write into the ID window is rejected
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'hF5, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, data_word(32'hCAFEF00D));
        check("rom_wr_err",   32'(error), 32'd1);
        check("rom_wr_ready", 32'(ready), 32'd1);
        check("rom_wr_areg",  32'(mon_a), 32'hF6);
        check("rom_wr_dreg",  mon_d,      32'h12345678);
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'hF5, 1'b1));
        expect_read("rom_f5", ID_WORD, 8'hF6, 1'b0);

        // Read at 0xFF: ID word and address wrap
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'hFF, 1'b1));
        expect_read("wrap", ID_WORD, 8'h00, 1'b0);

        // Simultaneous set-address and write: only the write happens
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h20, 1'b0));
        pulse(1'b1, 1'b1, 1'b0, data_word(32'hA5A50001));
        check("simul_areg",  32'(mon_a), 32'h21);
        check("simul_ready", 32'(ready), 32'd1);
        check("simul_err",   32'(error), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h20, 1'b1));
        expect_read("simul_rd", 32'hA5A50001, 8'h21, 1'b0);

        // Stray read-next while in RD_WAIT
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h10, 1'b1));
        check("stray_rdy_c1", 32'(ready), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, '0);
        check("stray_rdy_c2", 32'(ready), 32'd0);
        @(negedge clk);
        check("stray_ready", 32'(ready), 32'd1);
        check("stray_dreg",  mon_d,      32'hDEADBEEF);
        check("stray_err",   32'(error), 32'd1);
        check("stray_areg",  32'(mon_a), 32'h11);
        @(negedge clk);
        check("stray_areg_hold", 32'(mon_a), 32'h11);
        check("stray_err_hold",  32'(error), 32'd1);
        pulse(1'b0, 1'b0, 1'b1, '0);
        expect_read("after_stray", 32'h12345678, 8'h12, 1'b0);

        // Reset while in RD_WAIT
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h11, 1'b1));
        reset_n = 1'b0;
        #1;
        check("midrd_rst_ready", 32'(ready), 32'd1);
        check("midrd_rst_error", 32'(error), 32'd0);
        check("midrd_rst_areg",  32'(mon_a), 32'd0);
        check("midrd_rst_dreg",  mon_d,      32'd0);
        repeat (2) @(negedge clk);
        check("midrd_rst_dreg2", mon_d, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h11, 1'b1));
        expect_read("post_rst_rd1", 32'h12345678, 8'h12, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, addr_word(8'h10, 1'b1));
        expect_read("post_rst_rd0", 32'hDEADBEEF, 8'h11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
